// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared definitions for the iterative AES-128 encryptor: FSM encodings, rcon lookup and the
// forward S-box plus round primitives used by the datapath and key expansion.
package aes128_encrypt_iter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StDone  = 2'd2
    } aesState_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rconLookup(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte index i = row + 4*col, byte 0 at [127:120].
    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = sbox(s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_encrypt_iter_key_step.sv
// Combinational single-step AES-128 key expansion: one round key to the next.
module aes128_encrypt_iter_key_step
    import aes128_encrypt_iter_pkg::*;
(
    input  logic [127:0] inKey,
    input  logic [7:0]   rcon,
    output logic [127:0] outKey
);

    logic [31:0] w0, w1, w2, w3, rot, t;
    logic [31:0] o0, o1, o2, o3;

    always_comb begin
        w0  = inKey[127:96];
        w1  = inKey[95:64];
        w2  = inKey[63:32];
        w3  = inKey[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        o0  = w0 ^ t;
        o1  = w1 ^ o0;
        o2  = w2 ^ o1;
        o3  = w3 ^ o2;
        outKey = {o0, o1, o2, o3};
    end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional AES_ENC_LAST_KEY_OUT_EN adds a lastKey port carrying the final round key.
module aes128_encrypt_iter
    import aes128_encrypt_iter_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] inputData,
    input  logic [127:0] inputKey,
    input  logic         inValid,
    output logic         inReady,
    output logic [127:0] outputData,
    output logic         outValid,
    input  logic         outReady,
    output logic         busy
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0] lastKey
`endif
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : gBadRounds
        $error("NUM_ROUNDS must be in 1..10");
    end

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    aesState_e    stateQ, stateD;
    logic [3:0]   roundQ, roundD;
    logic [127:0] stQ, stD;
    logic [127:0] rkQ, rkD;
    logic [127:0] nextKey, shifted, roundOut;
    logic         load;

    aes128_encrypt_iter_key_step uKeyStep (
        .inKey  (rkQ),
        .rcon   (rconLookup(roundQ)),
        .outKey (nextKey)
    );

    // The final round skips MixColumns.
    always_comb begin
        shifted  = subShift(stQ);
        roundOut = ((roundQ == LastRound) ? shifted : mixColumns(shifted)) ^ nextKey;
    end

    always_comb begin
        stateD  = stateQ;
        roundD  = roundQ;
        stD     = stQ;
        rkD     = rkQ;
        inReady = (stateQ == StIdle) || ((stateQ == StDone) && outReady);
        load    = inValid && inReady;

        unique case (stateQ)
            StIdle, StDone: begin
                if (stateQ == StDone && outReady) begin
                    stateD = StIdle;
                end
                // A load in DONE retires the current block and starts the next with no bubble.
                if (load) begin
                    stD    = inputData ^ inputKey;
                    rkD    = inputKey;
                    roundD = 4'd1;
                    stateD = StRound;
                end
            end
            StRound: begin
                stD    = roundOut;
                rkD    = nextKey;
                roundD = roundQ + 4'd1;
                if (roundQ == LastRound) begin
                    stateD = StDone;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ <= StIdle;
            roundQ <= 4'd0;
            stQ    <= '0;
            rkQ    <= '0;
        end else begin
            stateQ <= stateD;
            roundQ <= roundD;
            stQ    <= stD;
            rkQ    <= rkD;
        end
    end

    assign outValid   = (stateQ == StDone);
    assign busy       = (stateQ == StRound);
    assign outputData = outValid ? stQ : '0;

`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign lastKey = outValid ? rkQ : '0;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: known-answer vectors, latency, backpressure,
// back-to-back blocks, mid-operation reset and ignored input during rounds.
module tb_aes128_encrypt_iter;

    logic         CLK;
    logic         RST;
    logic [127:0] inputData;
    logic [127:0] inputKey;
    logic         inValid;
    logic         inReady;
    logic [127:0] outputData;
    logic         outValid;
    logic         outReady;
    logic         busy;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] lastKey;
`endif

    aes128_encrypt_iter #(
        .NUM_ROUNDS (10)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .inputData  (inputData),
        .inputKey   (inputKey),
        .inValid    (inValid),
        .inReady    (inReady),
        .outputData (outputData),
        .outValid   (outValid),
        .outReady   (outReady),
        .busy       (busy)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        ,
        .lastKey    (lastKey)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] lk;
        bit           hasLk;
    } vec_t;

    vec_t vecs[3];
    vec_t sb[$];
    vec_t curExp;
    int   nCmp = 0;
    int   nErr = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Record handshakes the coming edge will perform, then advance to the next negedge.
    task automatic clk1();
        vec_t e;
        #1;
        if (!RST) begin
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL unexpected output: got %h expected none", outputData);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " ct"}, outputData, e.ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
                    if (e.hasLk) chk({e.name, " lastKey"}, lastKey, e.lk);
`endif
                end
            end
            if (inValid && inReady) sb.push_back(curExp);
        end
        @(negedge CLK);
    endtask

    task automatic waitValid(input int limit, output int edges);
        edges = 0;
        while (!outValid && edges < limit) begin
            clk1();
            edges++;
        end
        chk("outValid within bound", 128'(outValid), 128'(1));
    endtask

    task automatic loadVec(input vec_t v);
        inputKey  = v.key;
        inputData = v.pt;
        curExp    = v;
    endtask

    // Accept one block with outReady high, check latency, retire it.
    task automatic runOne(input vec_t v);
        int e;
        loadVec(v);
        inValid  = 1'b1;
        outReady = 1'b1;
        clk1();
        inValid = 1'b0;
        chk({v.name, " busy in round"}, 128'(busy), 128'(1));
        chk({v.name, " inReady in round"}, 128'(inReady), 128'(0));
        waitValid(40, e);
        chk({v.name, " latency"}, 128'(1 + e), 128'(11));
        clk1();
        chk({v.name, " outValid after retire"}, 128'(outValid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        vecs[0] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
        vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
        vecs[2] = '{"zero", 128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0};

        RST       = 1'b1;
        inValid   = 1'b0;
        outReady  = 1'b0;
        inputData = '0;
        inputKey  = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset inReady", 128'(inReady), 128'(1));
        chk("reset outValid", 128'(outValid), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset outputData", outputData, 128'h0);
        RST = 1'b0;

        for (int i = 0; i < 3; i++) runOne(vecs[i]);

        // Backpressure: output held for 20 cycles.
        loadVec(vecs[0]);
        inValid  = 1'b1;
        outReady = 1'b0;
        clk1();
        inValid = 1'b0;
        waitValid(40, e);
        for (int i = 0; i < 20; i++) begin
            chk("bp outputData stable", outputData, vecs[0].ct);
            chk("bp inReady low", 128'(inReady), 128'(0));
            clk1();
        end
        outReady = 1'b1;
        clk1();
        chk("bp outValid dropped", 128'(outValid), 128'(0));
        chk("bp inReady idle", 128'(inReady), 128'(1));
        chk("bp busy idle", 128'(busy), 128'(0));

        // Back-to-back with inValid held.
        loadVec(vecs[0]);
        inValid = 1'b1;
        clk1();
        loadVec(vecs[1]);
        waitValid(40, e);
        clk1();
        inValid = 1'b0;
        chk("b2b second busy", 128'(busy), 128'(1));
        waitValid(40, e);
        chk("b2b second latency", 128'(1 + e), 128'(11));
        clk1();
        chk("b2b scoreboard empty", 128'(sb.size()), 128'(0));

        // Reset at round 5 discards the block.
        loadVec(vecs[0]);
        inValid = 1'b1;
        clk1();
        inValid = 1'b0;
        repeat (4) clk1();
        RST = 1'b1;
        clk1();
        chk("rst mid outValid", 128'(outValid), 128'(0));
        chk("rst mid inReady", 128'(inReady), 128'(1));
        chk("rst mid busy", 128'(busy), 128'(0));
        chk("rst mid outputData", outputData, 128'h0);
        sb.delete();
        RST = 1'b0;
        runOne(vecs[0]);

        // Garbage and toggling inValid during rounds must be ignored.
        loadVec(vecs[0]);
        inValid = 1'b1;
        clk1();
        for (int i = 0; i < 8; i++) begin
            inValid   = ~inValid;
            inputData = {$urandom, $urandom, $urandom, $urandom};
            inputKey  = {$urandom, $urandom, $urandom, $urandom};
            clk1();
        end
        inValid = 1'b0;
        waitValid(40, e);
        clk1();

        chk("final scoreboard empty", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
